// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: size encodings, FSM states,
// byte-lane mask and alignment check.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } lsu_state_t;

    function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] offset);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << offset;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return addr_lo[0];
            SZ_W:    return |addr_lo[1:0];
            default: return |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: extracts and extends load data from a doubleword
// and merges store data into a read-back doubleword.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [63:0] rbuf,
    input  logic [63:0] wdata,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [2:0]  offset,
    output logic [63:0] load_data,
    output logic [63:0] store_data
);

    logic [63:0] shifted;
    logic [63:0] wshift;
    logic [7:0]  mask;

    assign shifted = rbuf >> {offset, 3'b000};
    assign wshift  = wdata << {offset, 3'b000};
    assign mask    = byte_mask(size, offset);

    always_comb begin
        load_data = shifted;
        case (size)
            SZ_B: load_data = is_unsigned ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}}, shifted[7:0]};
            SZ_H: load_data = is_unsigned ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            SZ_W: load_data = is_unsigned ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        store_data = rbuf;
        for (int k = 0; k < 8; k++) begin
            if (mask[k]) store_data[8*k +: 8] = wshift[8*k +: 8];
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// RV64 load/store front end for a doubleword-only data memory; sub-doubleword stores
// use read-modify-write. Optional counters enabled by LSU_STATS_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int D_ADDR_BITS = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [1:0]             req_size,
    input  logic                   req_unsigned,
    input  logic [D_ADDR_BITS-1:0] req_addr,
    input  logic [63:0]            req_wdata,
    output logic                   rsp_valid,
    output logic [63:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic                   d_mem_we,
    output logic [D_ADDR_BITS-1:0] d_mem_addr,
    inout  wire  [63:0]            d_mem_data,
`ifdef LSU_STATS_EN
    output logic [31:0]            stat_loads,
    output logic [31:0]            stat_stores,
    output logic [31:0]            stat_misaligned,
`endif
    output lsu_state_t             dbg_state
);

    // Handshake: a request transfers on a rising edge with req_valid & req_ready;
    // req_ready is high only in IDLE and every req_* field is latched at that edge.
    lsu_state_t  state;
    logic        a_we;
    logic [1:0]  a_size;
    logic        a_uns;
    logic [2:0]  a_off;
    logic [63:0] a_wdata;
    logic [63:0] rbuf;
    logic [63:0] align_src;
    logic [63:0] load_data;
    logic [63:0] store_data;

    assign req_ready  = (state == IDLE);
    assign dbg_state  = state;
    // In CAP the fresh memory word is on the bus; the load result is taken straight from it.
    assign align_src  = (state == CAP) ? d_mem_data : rbuf;
    assign d_mem_data = d_mem_we ? store_data : 64'bz;

    lsu_align u_align (
        .rbuf        (align_src),
        .wdata       (a_wdata),
        .size        (a_size),
        .is_unsigned (a_uns),
        .offset      (a_off),
        .load_data   (load_data),
        .store_data  (store_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_we       <= 1'b0;
            a_size     <= SZ_B;
            a_uns      <= 1'b0;
            a_off      <= 3'd0;
            a_wdata    <= 64'd0;
            rbuf       <= 64'd0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 64'd0;
            rsp_err    <= 1'b0;
            d_mem_we   <= 1'b0;
            d_mem_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_we    <= req_we;
                        a_size  <= req_size;
                        a_uns   <= req_unsigned;
                        a_off   <= req_addr[2:0];
                        a_wdata <= req_wdata;
                        if (is_misaligned(req_size, req_addr[2:0])) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 64'd0;
                            state     <= RESP;
                        end else begin
                            d_mem_addr <= {req_addr[D_ADDR_BITS-1:3], 3'b000};
                            if (req_we && req_size == SZ_D) begin
                                d_mem_we <= 1'b1;
                                state    <= WR;
                            end else begin
                                state <= RD;
                            end
                        end
                    end
                end
                RD: state <= CAP;
                CAP: begin
                    rbuf <= d_mem_data;
                    if (a_we) begin
                        d_mem_we <= 1'b1;
                        state    <= WR;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= load_data;
                        state     <= RESP;
                    end
                end
                WR: begin
                    d_mem_we  <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 64'd0;
                    state     <= RESP;
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LSU_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_loads      <= 32'd0;
            stat_stores     <= 32'd0;
            stat_misaligned <= 32'd0;
        end else if (state == RESP) begin
            if (rsp_err)   stat_misaligned <= stat_misaligned + 32'd1;
            else if (a_we) stat_stores     <= stat_stores + 32'd1;
            else           stat_loads      <= stat_loads + 32'd1;
        end
    end
`endif

endmodule
